// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game sequencer for the snake display pipeline (body, direction, food, BCD score).
// Optional macro WRAP_WALLS_EN: wall exits wrap to the opposite edge instead of ending the game.
module snake_game_ctrl #(
  parameter int          GRID_W          = 40,
  parameter int          GRID_H          = 30,
  parameter int          MAX_LEN         = 16,
  parameter int          INIT_LEN        = 3,
  parameter int          FRAMES_PER_STEP = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [1:0] move_state,
  input  logic [3:0] body_idx,
  output logic [5:0] body_x,
  output logic [4:0] body_y,
  output logic [4:0] body_len,
  output logic [5:0] food_x,
  output logic [4:0] food_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] score3,
  output logic [3:0] score4,
  output logic       running,
  output logic       game_over,
  output logic [2:0] debug_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_CHECK = 3'd3,
    S_FOOD  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    D_UP    = 2'b00,
    D_DOWN  = 2'b01,
    D_LEFT  = 2'b10,
    D_RIGHT = 2'b11
  } dir_t;

  localparam int          CW       = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);
  localparam logic [5:0]  X_LAST   = 6'(GRID_W - 1);
  localparam logic [4:0]  Y_LAST   = 5'(GRID_H - 1);
  localparam logic [5:0]  HEAD_X0  = 6'd20;
  localparam logic [4:0]  HEAD_Y0  = 5'd15;
  localparam logic [5:0]  FOOD_X0  = 6'd30;
  localparam logic [4:0]  FOOD_Y0  = 5'd15;
  localparam logic [4:0]  LEN_MAX  = 5'(MAX_LEN);
  localparam logic [4:0]  LEN_INIT = 5'(INIT_LEN);

`ifdef WRAP_WALLS_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  state_t        state;
  dir_t          dir;
  dir_t          next_dir;
  logic [CW-1:0] step_cnt;
  logic          grow_pending;
  logic [3:0]    chk_idx;
  logic [15:0]   lfsr;
  logic [5:0]    seg_x [MAX_LEN];
  logic [4:0]    seg_y [MAX_LEN];

  logic [5:0] new_x;
  logic [4:0] new_y;
  logic       wall;
  logic       wall_hit;
  logic       reverse;
  logic       chk_last;
  logic       chk_hit;
  logic       head_on_food;
  logic [5:0] cand_x;
  logic [4:0] cand_y;
  logic       cand_ok;
  logic       score_max;
  logic       do_init;

  assign body_x      = seg_x[body_idx];
  assign body_y      = seg_y[body_idx];
  assign debug_state = state;

  // Fibonacci LFSR, taps 16,14,13,11; free-running, only reset reloads it.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_comb begin
    new_x = seg_x[0];
    new_y = seg_y[0];
    wall  = 1'b0;
    case (next_dir)
      D_UP: begin
        if (seg_y[0] == 5'd0) begin wall = 1'b1; new_y = Y_LAST; end
        else new_y = seg_y[0] - 5'd1;
      end
      D_DOWN: begin
        if (seg_y[0] == Y_LAST) begin wall = 1'b1; new_y = 5'd0; end
        else new_y = seg_y[0] + 5'd1;
      end
      D_LEFT: begin
        if (seg_x[0] == 6'd0) begin wall = 1'b1; new_x = X_LAST; end
        else new_x = seg_x[0] - 6'd1;
      end
      default: begin
        if (seg_x[0] == X_LAST) begin wall = 1'b1; new_x = 6'd0; end
        else new_x = seg_x[0] + 6'd1;
      end
    endcase
  end

  assign wall_hit     = wall & ~WRAP;
  assign reverse      = (move_state == {dir[1], ~dir[0]});
  assign chk_last     = ({1'b0, chk_idx} == (body_len - 5'd1));
  assign chk_hit      = (seg_x[chk_idx] == seg_x[0]) && (seg_y[chk_idx] == seg_y[0]);
  assign head_on_food = (seg_x[0] == food_x) && (seg_y[0] == food_y);
  assign cand_x       = lfsr[5:0];
  assign cand_y       = lfsr[12:8];
  assign cand_ok      = ({1'b0, cand_x} < 7'(GRID_W)) && ({1'b0, cand_y} < 6'(GRID_H)) &&
                        !((cand_x == seg_x[0]) && (cand_y == seg_y[0]));
  assign score_max    = (score1 == 4'd9) && (score2 == 4'd9) && (score3 == 4'd9) && (score4 == 4'd9);
  // Restart from OVER shares the reset init path, except the LFSR.
  assign do_init      = reset || ((state == S_OVER) && start);

  always_ff @(posedge clk) begin
    if (do_init) begin
      state <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= HEAD_X0 - 6'(i);
        seg_y[i] <= HEAD_Y0;
      end
      body_len     <= LEN_INIT;
      dir          <= D_RIGHT;
      next_dir     <= D_RIGHT;
      step_cnt     <= '0;
      grow_pending <= 1'b0;
      chk_idx      <= 4'd1;
      food_x       <= FOOD_X0;
      food_y       <= FOOD_Y0;
      score1       <= 4'd0;
      score2       <= 4'd0;
      score3       <= 4'd0;
      score4       <= 4'd0;
      running      <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (!reverse) next_dir <= dir_t'(move_state);
          if (frame_tick) begin
            if (step_cnt == CNT_LAST) begin
              step_cnt <= '0;
              state    <= S_STEP;
            end else begin
              step_cnt <= step_cnt + CW'(1);
            end
          end
        end
        S_STEP: begin
          dir <= next_dir;
          if (wall_hit) begin
            state     <= S_OVER;
            running   <= 1'b0;
            game_over <= 1'b1;
          end else begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= new_x;
            seg_y[0] <= new_y;
            if (grow_pending) begin
              if (body_len != LEN_MAX) body_len <= body_len + 5'd1;
              grow_pending <= 1'b0;
            end
            chk_idx <= 4'd1;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (chk_hit) begin
            state     <= S_OVER;
            running   <= 1'b0;
            game_over <= 1'b1;
          end else if (chk_last) begin
            if (head_on_food) begin
              // BCD increment with ripple carry, pinned at 9999.
              if (!score_max) begin
                if (score1 != 4'd9) score1 <= score1 + 4'd1;
                else begin
                  score1 <= 4'd0;
                  if (score2 != 4'd9) score2 <= score2 + 4'd1;
                  else begin
                    score2 <= 4'd0;
                    if (score3 != 4'd9) score3 <= score3 + 4'd1;
                    else begin
                      score3 <= 4'd0;
                      score4 <= score4 + 4'd1;
                    end
                  end
                end
              end
              grow_pending <= 1'b1;
              state        <= S_FOOD;
            end else begin
              state <= S_RUN;
            end
          end else begin
            chk_idx <= chk_idx + 4'd1;
          end
        end
        S_FOOD: begin
          if (cand_ok) begin
            food_x <= cand_x;
            food_y <= cand_y;
            state  <= S_RUN;
          end
        end
        S_OVER: begin
          state <= S_OVER;
        end
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Game sequencer for the snake display pipeline. Owns snake body state, direction, food position and BCD score. Advances the game once every FRAMES_PER_STEP video frames, then runs a multi-cycle collision check and food respawn. Feeds the renderer (body read port, food) and the seven-segment controller (score digits).

Parameters:
GRID_W, 40, playfield width in cells (16-px cells, 640 px wide)
GRID_H, 30, playfield height in cells (480 px high)
MAX_LEN, 16, maximum body length in segments, including the head
INIT_LEN, 3, body length after reset or restart
FRAMES_PER_STEP, 8, frame_tick pulses per game step
LFSR_SEED, 16'hACE1, reset value of the 16-bit food LFSR (must be nonzero)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  one-cycle pulse; starts or restarts the game
move_state  in  2  requested direction: 00 up, 01 down, 10 left, 11 right
body_idx  in  4  body read index (0 = head)
body_x  out  6  x of segment body_idx, combinational
body_y  out  5  y of segment body_idx, combinational
body_len  out  5  current length
food_x  out  6  food x
food_y  out  5  food y
score1  out  4  BCD ones digit
score2  out  4  BCD tens digit
score3  out  4  BCD hundreds digit
score4  out  4  BCD thousands digit
running  out  1  high in RUN, STEP, CHECK and FOOD
game_over  out  1  high in OVER

Behaviour:
- Reset and restart init values:
  - state IDLE; head (20,15); seg[i] = (20-i,15) for i < INIT_LEN; body_len = INIT_LEN.
  - dir = next_dir = right; step counter 0; grow_pending 0.
  - food (30,15); scores 0; running 0; game_over 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Loads LFSR_SEED on reset, then shifts every cycle in every state; restart does not reload it.
- IDLE: start moves to RUN. All other inputs are ignored.
- RUN:
  - move_state is sampled every cycle into next_dir. A direct reversal of dir (up/down, left/right) is ignored.
  - frame_tick increments the step counter. A tick at count FRAMES_PER_STEP-1 clears the counter and moves to STEP.
  - start is ignored.
- STEP (1 cycle):
  - dir <= next_dir; new head = head + unit vector.
  - If the new head leaves the grid, go to OVER. Body is unchanged.
  - Otherwise seg[i] <= seg[i-1] and seg[0] <= new head.
  - If grow_pending: body_len += 1 (saturates at MAX_LEN) and grow_pending clears.
  - Then go to CHECK.
- CHECK:
  - idx runs 1..body_len-1, one comparison per cycle of seg[idx] against seg[0]. A match goes to OVER.
  - After the last index: if head == food, score increments, grow_pending sets, go to FOOD; else go to RUN.
  - Worst case MAX_LEN-1 cycles.
- FOOD:
  - Candidate is x = lfsr[5:0], y = lfsr[12:8].
  - Accept if x < GRID_W, y < GRID_H and the candidate is not the head; then food updates and the state goes to RUN.
  - Otherwise retry next cycle. Overlap with non-head body is allowed.
- OVER: game_over=1, everything frozen. start applies the init values except the LFSR and goes to IDLE.
- frame_tick outside RUN is dropped. The counter does not advance.
- Score: 4-digit BCD with per-digit carry. At 9999 it saturates and stays 9999.
- Body read: body_x/body_y for body_idx >= body_len return the stale register contents. The renderer must qualify them with body_len.
- reset in any state takes priority over all other activity and restores the init values on the next edge.

Optional Feature:
WRAP_WALLS_EN:
- Defined: leaving the grid wraps (x: -1→GRID_W-1, GRID_W→0; y likewise), and STEP never enters OVER for walls.
- Undefined: a wall exit goes to OVER as specified above.

Test Plan:
- Reset, start, 8 frame_ticks → head (21,15), seg1 (20,15), seg2 (19,15), body_len 3, running 1.
- While moving right, move_state=10 (left) then a step → head x+1 (reversal ignored). Then move_state=00 and a step → head y-1.
- 9 steps right from reset → head (29,15), score 0000. Step 10 → score1=1, FOOD accepts in-grid coordinates ≠ (30,15). Next step → body_len 4.
- Run right from reset to x=39, one more step → game_over 1, head stays (39,15), running 0. With WRAP_WALLS_EN → head (0,15), game continues.
- Grow to length 5, then up, left, down on consecutive steps → game_over 1 during CHECK. start → IDLE with init values and score 0000.
- Assert reset mid-CHECK → next cycle: all outputs at init values, state IDLE. Force the score to 9999, eat → stays 9999.
